mux421_sweep_gen: RTL



---
 rtl/mux421_sweep_gen_if.sv | 31 +++
 rtl/mux421_sweep_gen.sv | 117 +++++++++++
 2 files changed

// File: rtl/mux421_sweep_gen_if.sv
// Bundle between the mux sweep generator and its harness: mux drive/return
// pins plus the sweep control and result signals.
interface mux421_sweep_gen_if #(
  parameter int ERRW = 8
);
  logic            start;
  logic            Y;
  logic            Out0;
  logic            Out1;
  logic            Out2;
  logic            Out3;
  logic            Out4;
  logic            Out5;
  logic            busy;
  logic            done;
  logic [ERRW-1:0] err_cnt;
  logic            first_err_vld;
  logic [5:0]      first_err_vec;

  modport master (
    input  start, Y,
    output Out0, Out1, Out2, Out3, Out4, Out5,
    output busy, done, err_cnt, first_err_vld, first_err_vec
  );

  modport slave (
    output start, Y,
    input  Out0, Out1, Out2, Out3, Out4, Out5,
    input  busy, done, err_cnt, first_err_vld, first_err_vec
  );
endinterface

// File: rtl/mux421_sweep_gen.sv
// Sweeps the 4-to-1 mux through all 64 data/select combinations, holding each
// for HOLD+1 cycles and checking Y against the expected selected data bit.
module mux421_sweep_gen #(
  parameter int HOLD = 2,
  parameter int ERRW = 8
) (
  input  logic                clk,
  input  logic                rst,
  mux421_sweep_gen_if.master  sw
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0]      HOLD_LOAD = 8'(HOLD - 1);
  localparam logic [ERRW-1:0] ERR_MAX   = '1;

  state_t          state, state_nxt;
  logic [5:0]      vec;
  logic [7:0]      hold_cnt;
  logic [ERRW-1:0] err_q;
  logic            vld_q;
  logic [5:0]      fvec_q;
  logic [3:0]      dvec;
  logic            expected;
  logic            mismatch;
  logic            accept;

  assign dvec     = vec[3:0];
  assign expected = dvec[vec[5:4]];
  assign mismatch = sw.Y ^ expected;
  // start only counts when no sweep is running
  assign accept   = sw.start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (accept) state_nxt = DRIVE;
      DRIVE:      if (hold_cnt == 8'd0) state_nxt = CHECK;
      CHECK:      state_nxt = (vec == 6'd63) ? DONE : DRIVE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec      <= '0;
      hold_cnt <= '0;
      err_q    <= '0;
      vld_q    <= 1'b0;
      fvec_q   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            vec      <= '0;
            hold_cnt <= HOLD_LOAD;
            err_q    <= '0;
            vld_q    <= 1'b0;
            fvec_q   <= '0;
          end
        end
        DRIVE: begin
          if (hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;
        end
        CHECK: begin
          if (mismatch) begin
            if (err_q != ERR_MAX) err_q <= err_q + 1'b1;
            if (!vld_q) begin
              vld_q  <= 1'b1;
              fvec_q <= vec;
            end
          end
          if (vec != 6'd63) begin
            vec      <= vec + 6'd1;
            hold_cnt <= HOLD_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only, so Y and start never reach them.
  always_comb begin
    sw.Out0 = 1'b0;
    sw.Out1 = 1'b0;
    sw.Out2 = 1'b0;
    sw.Out3 = 1'b0;
    sw.Out4 = 1'b0;
    sw.Out5 = 1'b0;
    sw.busy = 1'b0;
    sw.done = 1'b0;
    case (state)
      DRIVE, CHECK: begin
        {sw.Out5, sw.Out4, sw.Out3, sw.Out2, sw.Out1, sw.Out0} = vec;
        sw.busy = 1'b1;
      end
      DONE:    sw.done = 1'b1;
      default: ;
    endcase
  end

  assign sw.err_cnt       = err_q;
  assign sw.first_err_vld = vld_q;
  assign sw.first_err_vec = fvec_q;

endmodule
